id_stage: RTL and testbench

- Registered, parametrised RV32I/RV64I instruction-decode stage with valid/ready handshakes on both sides.
- Sits between the instruction fetch/IR path and the register file/ALU.
- Decodes register addresses and a fully sign-extended immediate for all six formats (R/I/S/B/U/J), including LUI/AUIPC.
- Decoded entries queue in a DEPTH-entry FIFO so fetch and execute can stall independently.

---
 rtl/id_stage.sv | 178 +++++++++++++++++
 tb/tb_id_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Registered RV32I/RV64I decode stage: register fields and sign-extended immediate,
// queued in a DEPTH-entry FIFO. Define ID_ILLEGAL_CHECK_EN to build the illegal flag.
module id_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [31:0]       IN_INSTR,
    input  logic [XLEN-1:0]   IN_PC,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [REG_AW-1:0] OUT_RA1,
    output logic [REG_AW-1:0] OUT_RA2,
    output logic [REG_AW-1:0] OUT_WA,
    output logic [XLEN-1:0]   OUT_IMM,
    output logic [XLEN-1:0]   OUT_PC,
    output logic [2:0]        OUT_FMT,
    output logic              OUT_ILLEGAL
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_X = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [2:0]        fmt;
`ifdef ID_ILLEGAL_CHECK_EN
        logic              ill;
`endif
    } entry_t;

    entry_t      dec;
    fmt_e        fmt;
    logic [31:0] imm32;
    logic        use_rs1, use_rs2, use_rd;

    always_comb begin
        fmt     = FMT_X;
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (IN_INSTR[6:0])
            7'b0110011: begin
                fmt = FMT_R; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                fmt = FMT_I; use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
            end
            7'b0100011: begin
                fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{20{IN_INSTR[31]}}, IN_INSTR[31:25], IN_INSTR[11:7]};
            end
            7'b1100011: begin
                fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{19{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[7],
                         IN_INSTR[30:25], IN_INSTR[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt = FMT_U; use_rd = 1'b1;
                imm32 = {IN_INSTR[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt = FMT_J; use_rd = 1'b1;
                imm32 = {{11{IN_INSTR[31]}}, IN_INSTR[31], IN_INSTR[19:12],
                         IN_INSTR[20], IN_INSTR[30:21], 1'b0};
            end
            default: ;
        endcase

        dec     = '0;
        dec.ra1 = use_rs1 ? IN_INSTR[15 +: REG_AW] : '0;
        dec.ra2 = use_rs2 ? IN_INSTR[20 +: REG_AW] : '0;
        dec.wa  = use_rd  ? IN_INSTR[7 +: REG_AW]  : '0;
        // Signed size cast fills the upper bits on RV64.
        dec.imm = XLEN'($signed(imm32));
        dec.pc  = IN_PC;
        dec.fmt = fmt;
`ifdef ID_ILLEGAL_CHECK_EN
        dec.ill = (IN_INSTR[1:0] != 2'b11) || (fmt == FMT_X) ||
                  ((REG_AW == 4) && ((use_rs1 && IN_INSTR[19]) ||
                                     (use_rs2 && IN_INSTR[24]) ||
                                     (use_rd  && IN_INSTR[11])));
`endif
    end

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rdy_q, rdy_d;
    logic            push, pop, in_ready, out_valid;
    entry_t          head;

    assign in_ready  = rdy_q && (cnt_q != CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = IN_VALID && in_ready;
    assign pop       = out_valid && OUT_READY;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        rdy_d = 1'b1;
        if (FLUSH) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = dec;
                wr_d        = wr_q + PW'(1);
            end
            if (pop) rd_d = rd_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign head      = out_valid ? mem_q[rd_q] : '0;
    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid;
    assign OUT_RA1   = head.ra1;
    assign OUT_RA2   = head.ra2;
    assign OUT_WA    = head.wa;
    assign OUT_IMM   = head.imm;
    assign OUT_PC    = head.pc;
    assign OUT_FMT   = head.fmt;
`ifdef ID_ILLEGAL_CHECK_EN
    assign OUT_ILLEGAL = head.ill;
`else
    assign OUT_ILLEGAL = 1'b0;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode formats, FIFO flow control,
// flush, async reset, and an XLEN=64 instance for upper-bit sign extension.
module tb_id_stage;

    logic        clk, rst_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_pc;
    logic [4:0]  out_ra1, out_ra2, out_wa;
    logic [2:0]  out_fmt;

    logic        in_valid64, in_ready64, out_valid64, out_illegal64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc64, out_imm64, out_pc64;
    logic [4:0]  out_ra1_64, out_ra2_64, out_wa_64;
    logic [2:0]  out_fmt64;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        exp_ill;

    id_stage #(.XLEN(32), .REG_AW(5), .DEPTH(2)) u_dut (
        .CLK(clk), .RSTn(rst_n), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_INSTR(in_instr), .IN_PC(in_pc),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_RA1(out_ra1), .OUT_RA2(out_ra2), .OUT_WA(out_wa),
        .OUT_IMM(out_imm), .OUT_PC(out_pc), .OUT_FMT(out_fmt), .OUT_ILLEGAL(out_illegal)
    );

    id_stage #(.XLEN(64), .REG_AW(5), .DEPTH(2)) u_dut64 (
        .CLK(clk), .RSTn(rst_n), .FLUSH(1'b0),
        .IN_VALID(in_valid64), .IN_READY(in_ready64), .IN_INSTR(in_instr64), .IN_PC(in_pc64),
        .OUT_VALID(out_valid64), .OUT_READY(1'b1),
        .OUT_RA1(out_ra1_64), .OUT_RA2(out_ra2_64), .OUT_WA(out_wa_64),
        .OUT_IMM(out_imm64), .OUT_PC(out_pc64), .OUT_FMT(out_fmt64), .OUT_ILLEGAL(out_illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic [4:0] wa, input logic [31:0] imm,
                              input logic [2:0] fmt, input logic [31:0] pc);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_ra1"},   64'(out_ra1),   64'(ra1));
        check({tag, "_ra2"},   64'(out_ra2),   64'(ra2));
        check({tag, "_wa"},    64'(out_wa),    64'(wa));
        check({tag, "_imm"},   64'(out_imm),   64'(imm));
        check({tag, "_fmt"},   64'(out_fmt),   64'(fmt));
        check({tag, "_pc"},    64'(out_pc),    64'(pc));
    endtask

    initial begin
`ifdef ID_ILLEGAL_CHECK_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        in_valid64 = 1'b0; in_instr64 = '0; in_pc64 = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_imm",       64'(out_imm),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Decode of each format, streaming with OUT_READY=1.
        out_ready = 1'b1;
        push_one(32'hFFF10093, 32'h100);
        check_head("addi", 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF, 3'd1, 32'h100);
        check("addi_ill", 64'(out_illegal), 64'd0);
        push_one(32'hFE208EE3, 32'h104);
        check_head("beq", 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 3'd3, 32'h104);
        push_one(32'h001000EF, 32'h108);
        check_head("jal", 5'd0, 5'd0, 5'd1, 32'h00000800, 3'd5, 32'h108);
        push_one(32'h123452B7, 32'h10C);
        check_head("lui", 5'd0, 5'd0, 5'd5, 32'h12345000, 3'd4, 32'h10C);
        push_one(32'h002081B3, 32'h110);
        check_head("add", 5'd1, 5'd2, 5'd3, 32'h0, 3'd0, 32'h110);
        push_one(32'hFE20AE23, 32'h114);
        check_head("sw", 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 3'd2, 32'h114);
        push_one(32'h00000000, 32'h118);
        check_head("unk", 5'd0, 5'd0, 5'd0, 32'h0, 3'd7, 32'h118);
        check("unk_ill", 64'(out_illegal), 64'(exp_ill));
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("drain_imm",   64'(out_imm),   64'd0);
        check("drain_pc",    64'(out_pc),    64'd0);

        // Fill to DEPTH with consumer stalled; third push must be held.
        out_ready = 1'b0;
        push_one(32'hFFF10093, 32'h200);
        check("fill1_in_ready", 64'(in_ready), 64'd1);
        push_one(32'h123452B7, 32'h204);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_instr = 32'h001000EF; in_pc = 32'h208;
        tick();
        check("held_in_ready", 64'(in_ready), 64'd0);
        check("held_head_pc",  64'(out_pc),   64'h200);
        out_ready = 1'b1;
        check("ord_a_pc", 64'(out_pc), 64'h200);
        tick();
        check("ord_b_pc",  64'(out_pc),  64'h204);
        check("ord_b_imm", 64'(out_imm), 64'h12345000);
        tick();
        in_valid = 1'b0;
        check("ord_c_pc",  64'(out_pc),  64'h208);
        check("ord_c_fmt", 64'(out_fmt), 64'd5);
        tick();
        check("ord_empty", 64'(out_valid), 64'd0);

        // Flush with a simultaneous push discards everything.
        out_ready = 1'b0;
        push_one(32'hFFF10093, 32'h300);
        push_one(32'hFE208EE3, 32'h304);
        in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h308; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid",    64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready),  64'd1);
        check("flush_pc",       64'(out_pc),    64'd0);
        tick();
        check("flush_lost", 64'(out_valid), 64'd0);

        // XLEN=64 sign extension.
        in_valid64 = 1'b1; in_instr64 = 32'h800002B7; in_pc64 = 64'h1_0000_0400;
        tick();
        in_valid64 = 1'b0;
        check("x64_valid", 64'(out_valid64), 64'd1);
        check("x64_lui_imm", out_imm64, 64'hFFFFFFFF80000000);
        check("x64_lui_pc",  out_pc64,  64'h1_0000_0400);
        in_valid64 = 1'b1; in_instr64 = 32'hFFF10093;
        tick();
        in_valid64 = 1'b0;
        check("x64_addi_imm", out_imm64, 64'hFFFFFFFFFFFFFFFF);

        // Asynchronous reset mid-stream, between clock edges.
        push_one(32'h123452B7, 32'h400);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",    64'(out_valid), 64'd0);
        check("arst_imm",      64'(out_imm),   64'd0);
        check("arst_wa",       64'(out_wa),    64'd0);
        check("arst_in_ready", 64'(in_ready),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rerel_in_ready", 64'(in_ready),  64'd1);
        check("rerel_valid",    64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
